systolic_writeback: RTL and testbench

Downstream stage of the 8x8 systolic matrix-multiply tile. On start it snapshots the finished result tile (Out[r][c]) and the destination parameters. It then streams the valid rows of the tile to result memory as BW-word-wide masked writes, using a ready handshake. The snapshot frees the array for the next tile while writeback is in progress.

---
 rtl/systolic_writeback.sv | 142 ++++++++++++++
 tb/tb_systolic_writeback.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_writeback.sv
// Writeback stage for the systolic matrix-multiply tile: snapshots a finished
// result tile and streams its valid rows to result memory as masked BW-word beats.
module systolic_writeback #(
    parameter int N          = 8,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int BW         = 4,
    parameter int DIM_WIDTH  = 6
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic [N*N*DATA_WIDTH-1:0]    tile,
    input  logic [ADDR_WIDTH-1:0]        base_R,
    input  logic [DIM_WIDTH-1:0]         stride,
    input  logic [3:0]                   dim_row,
    input  logic [3:0]                   dim_col,
    input  logic                         write_ready,
    output logic                         write,
    output logic [ADDR_WIDTH-1:0]        write_addr,
    output logic [BW*DATA_WIDTH-1:0]     writedata,
    output logic [BW-1:0]                write_mask,
    output logic                         busy,
    output logic                         done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam int TILE_BITS = N * N * DATA_WIDTH;
    localparam int IDX_W     = (N > 1) ? $clog2(N) : 1;

    logic [1:0]            state_q;
    logic [TILE_BITS-1:0]  snap_q;
    logic [ADDR_WIDTH-1:0] row_addr_q;
    logic [DIM_WIDTH-1:0]  stride_q;
    logic [3:0]            rows_q;
    logic [3:0]            cols_q;
    logic [3:0]            chunks_q;
    logic [3:0]            row_q;
    logic [3:0]            chunk_q;

    logic [3:0]            rows_clamped;
    logic [3:0]            cols_clamped;
    logic [3:0]            chunks_calc;
    logic                  last_chunk;
    logic                  last_row;
    logic [IDX_W-1:0]      row_idx;

    logic [DATA_WIDTH-1:0] elem [N][N];

    always_comb begin
        rows_clamped = (dim_row > 4'(N)) ? 4'(N) : dim_row;
        cols_clamped = (dim_col > 4'(N)) ? 4'(N) : dim_col;
        chunks_calc  = 4'((32'(cols_clamped) + 32'(BW) - 32'd1) / 32'(BW));
        last_chunk   = (chunk_q == chunks_q - 4'd1);
        last_row     = (row_q == rows_q - 4'd1);
        row_idx      = IDX_W'(row_q);
    end

    // Row base address is carried as a running sum (base_R + r*stride)
    // instead of multiplying every beat; wraps modulo 2^ADDR_WIDTH.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            snap_q     <= '0;
            row_addr_q <= '0;
            stride_q   <= '0;
            rows_q     <= '0;
            cols_q     <= '0;
            chunks_q   <= '0;
            row_q      <= '0;
            chunk_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        snap_q     <= tile;
                        row_addr_q <= base_R;
                        stride_q   <= stride;
                        rows_q     <= rows_clamped;
                        cols_q     <= cols_clamped;
                        chunks_q   <= chunks_calc;
                        row_q      <= '0;
                        chunk_q    <= '0;
                        if (rows_clamped == 4'd0 || cols_clamped == 4'd0)
                            state_q <= S_DONE;
                        else
                            state_q <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (write_ready) begin
                        if (!last_chunk) begin
                            chunk_q <= chunk_q + 4'd1;
                        end else begin
                            chunk_q    <= '0;
                            row_q      <= row_q + 4'd1;
                            row_addr_q <= row_addr_q + ADDR_WIDTH'(stride_q);
                            if (last_row)
                                state_q <= S_DONE;
                        end
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        write      = (state_q == S_WRITE);
        done       = (state_q == S_DONE);
        busy       = write || done;
        write_addr = '0;
        if (write)
            write_addr = row_addr_q + ADDR_WIDTH'(32'(chunk_q) * 32'(BW));
    end

    for (genvar r = 0; r < N; r++) begin : g_row
        for (genvar c = 0; c < N; c++) begin : g_col
            assign elem[r][c] = snap_q[(r*N+c)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Lanes past the tile edge carry zero; the mask alone reflects dim_col.
    for (genvar j = 0; j < BW; j++) begin : g_lane
        logic [31:0]      col_w;
        logic [IDX_W-1:0] col_idx;
        logic             in_tile;

        assign col_w   = 32'(chunk_q) * 32'(BW) + 32'(j);
        assign col_idx = IDX_W'(col_w);
        assign in_tile = (col_w < 32'(N));

        assign writedata[j*DATA_WIDTH +: DATA_WIDTH] =
            (write && in_tile) ? elem[row_idx][col_idx] : '0;
        assign write_mask[j] = write && (col_w < 32'(cols_q));
    end

endmodule

// File: tb/tb_systolic_writeback.sv
// Directed self-checking bench for systolic_writeback: full, partial, backpressure,
// zero/clamp, address wrap with ignored start, and asynchronous reset mid-transfer.
module tb_systolic_writeback;

    localparam int N  = 8;
    localparam int DW = 32;
    localparam int AW = 12;
    localparam int BW = 4;
    localparam int SW = 6;

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 start;
    logic [N*N*DW-1:0]    tile;
    logic [AW-1:0]        base_R;
    logic [SW-1:0]        stride;
    logic [3:0]           dim_row;
    logic [3:0]           dim_col;
    logic                 write_ready;
    logic                 write;
    logic [AW-1:0]        write_addr;
    logic [BW*DW-1:0]     writedata;
    logic [BW-1:0]        write_mask;
    logic                 busy;
    logic                 done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [N*N*DW-1:0] tile_a;
    logic [AW-1:0]     got_addr[$];
    logic [BW*DW-1:0]  got_data[$];
    logic [BW-1:0]     got_mask[$];

    always #5 clock = ~clock;

    systolic_writeback #(
        .N(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BW(BW), .DIM_WIDTH(SW)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .tile(tile),
        .base_R(base_R), .stride(stride), .dim_row(dim_row), .dim_col(dim_col),
        .write_ready(write_ready), .write(write), .write_addr(write_addr),
        .writedata(writedata), .write_mask(write_mask), .busy(busy), .done(done)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] elem(input logic [N*N*DW-1:0] t, input int r, input int c);
        return t[(r*N+c)*DW +: DW];
    endfunction

    // Launches one transfer and checks every presented beat against a reference
    // list built from the original tile; stall_at/stall_len drop write_ready.
    task automatic run_xfer(input string name, input logic [AW-1:0] base, input logic [SW-1:0] str,
                            input logic [3:0] drow, input logic [3:0] dcol,
                            input int stall_at, input int stall_len, input int inject_at,
                            input int exp_done);
        int rows, cols, nchunk, n_exp, accepted, stalls, done_cyc;
        logic [AW-1:0]    ea[16];
        logic [BW*DW-1:0] ed[16];
        logic [BW-1:0]    em[16];

        rows   = (int'(drow) > N) ? N : int'(drow);
        cols   = (int'(dcol) > N) ? N : int'(dcol);
        nchunk = (cols + BW - 1) / BW;
        n_exp  = rows * nchunk;
        for (int r = 0; r < rows; r++)
            for (int k = 0; k < nchunk; k++) begin
                ea[r*nchunk+k] = AW'(int'(base) + r*int'(str) + k*BW);
                for (int j = 0; j < BW; j++) begin
                    ed[r*nchunk+k][j*DW +: DW] = (k*BW+j < N) ? elem(tile_a, r, k*BW+j) : '0;
                    em[r*nchunk+k][j] = (k*BW+j < cols);
                end
            end

        got_addr.delete(); got_data.delete(); got_mask.delete();
        accepted = 0; stalls = 0; done_cyc = -1;

        @(negedge clock);
        tile = tile_a; base_R = base; stride = str; dim_row = drow; dim_col = dcol;
        start = 1'b1; write_ready = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            if (inject_at > 0 && cyc == inject_at) begin
                start = 1'b1;
                tile  = ~tile_a;
            end else begin
                start = 1'b0;
            end
            write_ready = !(accepted == stall_at && stalls < stall_len);
            #1;
            if (done) begin
                done_cyc = cyc;
                check({name, " write during done"}, write, 0);
                break;
            end
            if (write) begin
                if (accepted < n_exp) begin
                    check($sformatf("%s beat%0d addr", name, accepted), write_addr, ea[accepted]);
                    check($sformatf("%s beat%0d data", name, accepted), writedata, ed[accepted]);
                    check($sformatf("%s beat%0d mask", name, accepted), write_mask, em[accepted]);
                end else begin
                    check({name, " extra beat"}, accepted, n_exp);
                end
                if (write_ready) begin
                    accepted++;
                    got_addr.push_back(write_addr);
                    got_data.push_back(writedata);
                    got_mask.push_back(write_mask);
                end else begin
                    stalls++;
                end
            end
            @(negedge clock);
        end
        start = 1'b0; tile = tile_a; write_ready = 1'b1;
        check({name, " done cycle"}, done_cyc, exp_done);
        check({name, " beat count"}, accepted, n_exp);
        check({name, " stall cycles"}, stalls, (stall_at >= 0) ? stall_len : 0);
        @(negedge clock);
        #1;
        check({name, " done one cycle"}, done, 0);
        check({name, " busy after done"}, busy, 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        logic [AW-1:0] pa[6];

        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                tile_a[(r*N+c)*DW +: DW] = DW'(r*8 + c);
        tile = tile_a; start = 1'b0; base_R = '0; stride = '0;
        dim_row = '0; dim_col = '0; write_ready = 1'b1;

        reset = 1'b1;
        #12;
        check("reset write", write, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset addr", write_addr, 0);
        check("reset data", writedata, 0);
        check("reset mask", write_mask, 0);
        @(negedge clock);
        reset = 1'b0;

        run_xfer("full", 12'd100, 6'd8, 4'd8, 4'd8, -1, 0, 0, 17);
        if (got_addr.size() == 16) begin
            check("full beat0 data", got_data[0], {32'd3, 32'd2, 32'd1, 32'd0});
            check("full beat0 mask", got_mask[0], 4'b1111);
            check("full last addr", got_addr[15], 160);
            check("full beat15 data", got_data[15], {32'd63, 32'd62, 32'd61, 32'd60});
        end

        run_xfer("partial", 12'd0, 6'd5, 4'd3, 4'd5, -1, 0, 0, 7);
        pa = '{12'd0, 12'd4, 12'd5, 12'd9, 12'd10, 12'd14};
        if (got_addr.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                check($sformatf("partial addr%0d", i), got_addr[i], pa[i]);
                check($sformatf("partial mask%0d", i), got_mask[i], (i % 2 == 0) ? 4'b1111 : 4'b0001);
            end
            check("partial addr4 data", got_data[1], {32'd7, 32'd6, 32'd5, 32'd4});
        end

        run_xfer("backpressure", 12'd100, 6'd8, 4'd8, 4'd8, 1, 3, 0, 20);
        if (got_addr.size() >= 3) begin
            check("backpressure beat1 addr", got_addr[1], 104);
            check("backpressure beat2 addr", got_addr[2], 108);
        end

        run_xfer("zero cols", 12'd100, 6'd8, 4'd8, 4'd0, -1, 0, 0, 1);
        run_xfer("zero rows", 12'd100, 6'd8, 4'd0, 4'd5, -1, 0, 0, 1);
        run_xfer("clamp rows", 12'd100, 6'd8, 4'd12, 4'd8, -1, 0, 0, 17);

        run_xfer("wrap", 12'd4090, 6'd8, 4'd8, 4'd8, -1, 0, 5, 17);
        if (got_addr.size() == 16) begin
            check("wrap row0 chunk1 addr", got_addr[1], 4094);
            check("wrap row1 addr", got_addr[2], 2);
            check("wrap row7 data", got_data[14], {32'd59, 32'd58, 32'd57, 32'd56});
        end

        // Reset after five accepted beats, then a clean transfer.
        @(negedge clock);
        tile = tile_a; base_R = 12'd100; stride = 6'd8; dim_row = 4'd8; dim_col = 4'd8;
        write_ready = 1'b1; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        acc = 0;
        for (int cyc = 1; cyc <= 40 && acc < 5; cyc++) begin
            #1;
            if (write && write_ready) acc++;
            @(negedge clock);
        end
        check("midreset beats before reset", acc, 5);
        #2;
        reset = 1'b1;
        #1;
        check("midreset write", write, 0);
        check("midreset busy", busy, 0);
        check("midreset done", done, 0);
        check("midreset mask", write_mask, 0);
        @(negedge clock);
        #1;
        check("midreset no done", done, 0);
        reset = 1'b0;
        run_xfer("after reset", 12'd100, 6'd8, 4'd8, 4'd8, -1, 0, 0, 17);
        if (got_addr.size() == 16)
            check("after reset first addr", got_addr[0], 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
